// File: rtl/rayforge_vga_timing.sv
// VGA raster timing generator: pixel/line counters, horizontal and vertical
// phase FSMs, cycle-aligned sync/blank/pulse outputs. Macro RAYFORGE_FRAME_CNT_EN adds a frame counter.
module rayforge_vga_timing #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  output logic [9:0] hpos,
  output logic [9:0] vpos,
  output logic       hsync,
  output logic       vsync,
  output logic       display_on,
  output logic       line_start,
  output logic       frame_start,
  output logic [7:0] frame_cnt
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] H_FRONT_START = 10'(H_ACTIVE);
  localparam logic [9:0] H_SYNC_START  = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] H_BACK_START  = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] H_LAST        = 10'(H_TOTAL - 1);

  localparam logic [9:0] V_FRONT_START = 10'(V_ACTIVE);
  localparam logic [9:0] V_SYNC_START  = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] V_BACK_START  = 10'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [9:0] V_LAST        = 10'(V_TOTAL - 1);

  typedef enum logic [1:0] {H_ACT, H_FRONT, H_SYN, H_BACK} h_state_t;
  typedef enum logic [1:0] {V_ACT, V_FRONT, V_SYN, V_BACK} v_state_t;

  h_state_t   h_state, h_state_next;
  v_state_t   v_state, v_state_next;
  logic [9:0] h_next, v_next;
  logic       h_wrap, consistent;

  // Phase that a given position must be in; used to catch state/counter disagreement.
  function automatic h_state_t h_decode(input logic [9:0] h);
    if (h < H_FRONT_START)     return H_ACT;
    else if (h < H_SYNC_START) return H_FRONT;
    else if (h < H_BACK_START) return H_SYN;
    else                       return H_BACK;
  endfunction

  function automatic v_state_t v_decode(input logic [9:0] v);
    if (v < V_FRONT_START)     return V_ACT;
    else if (v < V_SYNC_START) return V_FRONT;
    else if (v < V_BACK_START) return V_SYN;
    else                       return V_BACK;
  endfunction

  // NOTE: every signal written here gets a default first so no path leaves it unassigned (no latches).
  always_comb begin
    consistent = (hpos <= H_LAST) && (vpos <= V_LAST) &&
                 (h_state == h_decode(hpos)) && (v_state == v_decode(vpos));
    h_wrap     = (hpos == H_LAST);
    h_next     = h_wrap ? 10'd0 : hpos + 10'd1;
    v_next     = vpos;
    if (h_wrap) v_next = (vpos == V_LAST) ? 10'd0 : vpos + 10'd1;

    h_state_next = h_state;
    case (h_state)
      H_ACT:   if (h_next == H_FRONT_START) h_state_next = H_FRONT;
      H_FRONT: if (h_next == H_SYNC_START)  h_state_next = H_SYN;
      H_SYN:   if (h_next == H_BACK_START)  h_state_next = H_BACK;
      H_BACK:  if (h_wrap)                  h_state_next = H_ACT;
      default:                              h_state_next = H_ACT;
    endcase

    v_state_next = v_state;
    if (h_wrap) begin
      case (v_state)
        V_ACT:   if (v_next == V_FRONT_START) v_state_next = V_FRONT;
        V_FRONT: if (v_next == V_SYNC_START)  v_state_next = V_SYN;
        V_SYN:   if (v_next == V_BACK_START)  v_state_next = V_BACK;
        V_BACK:  if (v_next == 10'd0)         v_state_next = V_ACT;
        default:                              v_state_next = V_ACT;
      endcase
    end

    // Any disagreement between phase and position restarts the raster at the origin.
    if (!consistent) begin
      h_next       = 10'd0;
      v_next       = 10'd0;
      h_state_next = H_ACT;
      v_state_next = V_ACT;
    end
  end

  // Outputs are computed from the next position so they line up with hpos/vpos.
  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hpos        <= 10'd0;
      vpos        <= 10'd0;
      h_state     <= H_ACT;
      v_state     <= V_ACT;
      hsync       <= 1'b1;
      vsync       <= 1'b1;
      display_on  <= 1'b1;
      line_start  <= 1'b1;
      frame_start <= 1'b1;
    end else if (ena) begin
      hpos        <= h_next;
      vpos        <= v_next;
      h_state     <= h_state_next;
      v_state     <= v_state_next;
      hsync       <= (h_state_next != H_SYN);
      vsync       <= (v_state_next != V_SYN);
      display_on  <= (h_state_next == H_ACT) && (v_state_next == V_ACT);
      line_start  <= (h_next == 10'd0);
      frame_start <= (h_next == 10'd0) && (v_next == 10'd0);
    end
  end

`ifdef RAYFORGE_FRAME_CNT_EN
  logic frame_wrap;
  // A recovery jump to 0,0 is not a frame boundary, so it does not count.
  assign frame_wrap = consistent && h_wrap && (vpos == V_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                 frame_cnt <= 8'd0;
    else if (ena && frame_wrap) frame_cnt <= frame_cnt + 8'd1;
  end
`else
  assign frame_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_rayforge_vga_timing.sv
// Directed bench: a default-timing instance for line-level checks and a
// scaled-down instance (16x10 raster) for frame-level checks.
module tb_rayforge_vga_timing;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Default-timing instance
  logic       rst_n_d, ena_d;
  logic [9:0] hpos_d, vpos_d;
  logic       hsync_d, vsync_d, display_on_d, line_start_d, frame_start_d;
  logic [7:0] frame_cnt_d;

  // Small instance: H 8+2+3+3=16, V 6+1+2+1=10, frame = 160 cycles
  logic       rst_n_s, ena_s;
  logic [9:0] hpos_s, vpos_s;
  logic       hsync_s, vsync_s, display_on_s, line_start_s, frame_start_s;
  logic [7:0] frame_cnt_s;

  rayforge_vga_timing dut_d (
    .clk(clk), .rst_n(rst_n_d), .ena(ena_d),
    .hpos(hpos_d), .vpos(vpos_d), .hsync(hsync_d), .vsync(vsync_d),
    .display_on(display_on_d), .line_start(line_start_d),
    .frame_start(frame_start_d), .frame_cnt(frame_cnt_d)
  );

  rayforge_vga_timing #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(1)
  ) dut_s (
    .clk(clk), .rst_n(rst_n_s), .ena(ena_s),
    .hpos(hpos_s), .vpos(vpos_s), .hsync(hsync_s), .vsync(vsync_s),
    .display_on(display_on_s), .line_start(line_start_s),
    .frame_start(frame_start_s), .frame_cnt(frame_cnt_s)
  );

  int n_cmp = 0;
  int n_bad = 0;

  function automatic logic [7:0] exp_fc(input int frames);
`ifdef RAYFORGE_FRAME_CNT_EN
    return 8'(frames % 256);
`else
    return 8'd0;
`endif
  endfunction

  // Releasing on a falling edge leaves the sample point at cycle 0.
  task automatic reset_d();
    rst_n_d = 1'b0;
    ena_d   = 1'b1;
    @(negedge clk);
    rst_n_d = 1'b1;
  endtask

  task automatic reset_s();
    rst_n_s = 1'b0;
    ena_s   = 1'b1;
    @(negedge clk);
    rst_n_s = 1'b1;
  endtask

  task automatic test_reset();
    logic [30:0] got, exp;
    rst_n_d = 1'b0; ena_d = 1'b1;
    rst_n_s = 1'b0; ena_s = 1'b1;
    #12;
    got = {hpos_d, vpos_d, hsync_d, vsync_d, display_on_d, line_start_d, frame_start_d, frame_cnt_d};
    exp = {10'd0, 10'd0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 8'd0};
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL reset_state: got %h expected %h", got, exp);
    end
  endtask

  task automatic test_line();
    logic [23:0] got, exp;
    int h, v, hs_low, de_low, shown;
    hs_low = 0; de_low = 0; shown = 0;
    reset_d();
    for (int c = 0; c <= 800; c++) begin
      h   = c % 800;
      v   = c / 800;
      exp = {10'(h), 10'(v), !(h >= 656 && h <= 751), (h < 640 && v < 480),
             (h == 0), (h == 0 && v == 0)};
      got = {hpos_d, vpos_d, hsync_d, display_on_d, line_start_d, frame_start_d};
      n_cmp++;
      if (got !== exp) begin
        n_bad++;
        if (shown < 5) $display("FAIL line_cycle_%0d: got %h expected %h", c, got, exp);
        shown++;
      end
      if (c < 800) begin
        if (!hsync_d) hs_low++;
        if (!display_on_d) de_low++;
        @(negedge clk);
      end
    end
    n_cmp++;
    if (hs_low != 96) begin
      n_bad++;
      $display("FAIL hsync_width: got %0d expected 96", hs_low);
    end
    n_cmp++;
    if (de_low != 160) begin
      n_bad++;
      $display("FAIL blank_width: got %0d expected 160", de_low);
    end
  endtask

  task automatic test_hold();
    logic [30:0] got, exp;
    int shown;
    shown = 0;
    reset_d();
    repeat (700) @(negedge clk);
    exp = {10'd700, 10'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0};
    ena_d = 1'b0;
    for (int i = 0; i <= 50; i++) begin
      got = {hpos_d, vpos_d, hsync_d, vsync_d, display_on_d, line_start_d, frame_start_d, frame_cnt_d};
      n_cmp++;
      if (got !== exp) begin
        n_bad++;
        if (shown < 5) $display("FAIL hold_cycle_%0d: got %h expected %h", i, got, exp);
        shown++;
      end
      if (i < 50) @(negedge clk);
    end
    ena_d = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (hpos_d !== 10'd701 || vpos_d !== 10'd0) begin
      n_bad++;
      $display("FAIL hold_resume: got h=%0d v=%0d expected h=701 v=0", hpos_d, vpos_d);
    end
  endtask

  task automatic test_frame();
    logic [32:0] got, exp;
    int h, v, vs_low, shown;
    vs_low = 0; shown = 0;
    reset_s();
    for (int c = 0; c <= 160; c++) begin
      h   = c % 16;
      v   = (c / 16) % 10;
      exp = {10'(h), 10'(v), !(h >= 10 && h <= 12), !(v >= 7 && v <= 8),
             (h < 8 && v < 6), (h == 0), (h == 0 && v == 0),
             (c == 160) ? exp_fc(1) : 8'd0};
      got = {hpos_s, vpos_s, hsync_s, vsync_s, display_on_s, line_start_s,
             frame_start_s, frame_cnt_s};
      n_cmp++;
      if (got !== exp) begin
        n_bad++;
        if (shown < 5) $display("FAIL frame_cycle_%0d: got %h expected %h", c, got, exp);
        shown++;
      end
      if (c < 160) begin
        if (!vsync_s) vs_low++;
        @(negedge clk);
      end
    end
    n_cmp++;
    if (vs_low != 32) begin
      n_bad++;
      $display("FAIL vsync_width: got %0d expected 32", vs_low);
    end
  endtask

  task automatic test_reset_midframe();
    logic [30:0] got, exp;
    reset_s();
    repeat (160 + 139) @(negedge clk);
    got = {hpos_s, vpos_s, hsync_s, vsync_s, display_on_s, line_start_s, frame_start_s, frame_cnt_s};
    exp = {10'd11, 10'd8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, exp_fc(1)};
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL pre_reset_state: got %h expected %h", got, exp);
    end
    rst_n_s = 1'b0;
    #1;
    got = {hpos_s, vpos_s, hsync_s, vsync_s, display_on_s, line_start_s, frame_start_s, frame_cnt_s};
    exp = {10'd0, 10'd0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 8'd0};
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL async_reset: got %h expected %h", got, exp);
    end
    @(negedge clk);
    rst_n_s = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (hpos_s !== 10'd1 || vpos_s !== 10'd0) begin
      n_bad++;
      $display("FAIL reset_resume: got h=%0d v=%0d expected h=1 v=0", hpos_s, vpos_s);
    end
  endtask

  task automatic test_frame_wrap();
    logic [27:0] got, exp;
    reset_s();
    repeat (256 * 160 - 1) @(negedge clk);
    got = {hpos_s, vpos_s, frame_cnt_s};
    exp = {10'd15, 10'd9, exp_fc(255)};
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL frame_cnt_before_wrap: got %h expected %h", got, exp);
    end
    @(negedge clk);
    got = {hpos_s, vpos_s, frame_cnt_s};
    exp = {10'd0, 10'd0, exp_fc(256)};
    n_cmp++;
    if (got !== exp || frame_start_s !== 1'b1) begin
      n_bad++;
      $display("FAIL frame_cnt_wrap: got %h fs=%b expected %h fs=1", got, frame_start_s, exp);
    end
  endtask

  initial begin
    test_reset();
    test_line();
    test_hold();
    test_frame();
    test_reset_midframe();
    test_frame_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/rayforge_vga_timing.md
RAYFORGE_VGA_TIMING -- requirements
Module: rayforge_vga_timing

Interface
- REQ-001 SHALL have parameter H_ACTIVE, default 640: visible pixels per line.
- REQ-002 SHALL have parameter H_FP, default 16: horizontal front porch, in pixels.
- REQ-003 SHALL have parameter H_SYNC, default 96: hsync pulse width, in pixels.
- REQ-004 SHALL have parameter H_BP, default 48: horizontal back porch, in pixels.
- REQ-005 SHALL have parameter V_ACTIVE, default 480: visible lines per frame.
- REQ-006 SHALL have parameter V_FP, default 10: vertical front porch, in lines.
- REQ-007 SHALL have parameter V_SYNC, default 2: vsync pulse width, in lines.
- REQ-008 SHALL have parameter V_BP, default 33: vertical back porch, in lines.
- REQ-009 SHALL have port clk, input, 1 bit: the single pixel clock; all state changes on its rising edge.
- REQ-010 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
- REQ-011 SHALL have port ena, input, 1 bit: advance enable; when low all state holds.
- REQ-012 SHALL have port hpos, output, 10 bits: current pixel column, 0..H_TOTAL-1.
- REQ-013 SHALL have port vpos, output, 10 bits: current line, 0..V_TOTAL-1.
- REQ-014 SHALL have port hsync, output, 1 bit: horizontal sync, active low.
- REQ-015 SHALL have port vsync, output, 1 bit: vertical sync, active low.
- REQ-016 SHALL have port display_on, output, 1 bit: high when hpos<H_ACTIVE and vpos<V_ACTIVE.
- REQ-017 SHALL have port line_start, output, 1 bit: one-cycle pulse while hpos==0.
- REQ-018 SHALL have port frame_start, output, 1 bit: one-cycle pulse while hpos==0 and vpos==0.
- REQ-019 SHALL have port frame_cnt, output, 8 bits: frame counter (see Configuration).

Function
- REQ-020 SHALL define H_TOTAL=H_ACTIVE+H_FP+H_SYNC+H_BP (800) and V_TOTAL=V_ACTIVE+V_FP+V_SYNC+V_BP (525).
- REQ-021 SHALL run a horizontal FSM with states H_ACT, H_FRONT, H_SYN, H_BACK, entered at hpos 0, H_ACTIVE, H_ACTIVE+H_FP and H_ACTIVE+H_FP+H_SYNC respectively; H_BACK returns to H_ACT on wrap.
- REQ-022 SHALL run a vertical FSM with states V_ACT, V_FRONT, V_SYN, V_BACK, at the equivalent vpos boundaries, stepping only on horizontal wrap.
- REQ-023 SHALL increment hpos by 1 per enabled cycle; at hpos==H_TOTAL-1 it SHALL wrap to 0 and advance vpos in the same edge.
- REQ-024 SHALL wrap vpos from V_TOTAL-1 to 0 when the horizontal wrap occurs on line V_TOTAL-1 (simultaneous wrap).
- REQ-025 SHALL register hsync, vsync, display_on, line_start and frame_start so that they are cycle-aligned with the hpos/vpos values on the same cycle, with zero cycles of offset.
- REQ-026 SHALL drive hsync low exactly while in H_SYN (hpos 656..751 at defaults), and vsync low exactly while in V_SYN (vpos 490..491 at defaults).
- REQ-027 SHALL, with ena low, freeze hpos, vpos, the FSM states and frame_cnt; the pulse outputs SHALL also hold their values, and no pulse is duplicated on resume.
- REQ-028 SHALL produce a FSM state and counter values that are always consistent; an unreachable encoding SHALL recover to H_ACT/V_ACT at position 0,0 on the next enabled cycle.

Reset
- REQ-029 SHALL, on rst_n low, asynchronously set hpos=0, vpos=0, both FSMs to their ACT state, hsync=1, vsync=1, display_on=1, line_start=1, frame_start=1 and frame_cnt=0.
- REQ-030 SHALL resume counting from 0,0 on the first enabled edge after rst_n deasserts; assertion mid-line SHALL abort the frame with no partial sync pulse remaining.

Configuration
- REQ-031 SHALL gate the frame counter with macro RAYFORGE_FRAME_CNT_EN.
- REQ-032 SHALL, when the macro is defined, increment frame_cnt modulo 256 on each vpos wrap to 0.
- REQ-033 SHALL, when the macro is undefined, tie frame_cnt to constant 0 and synthesize no counter flops.

Verification
- REQ-034 SHALL verify: reset, ena=1, 800 cycles -> hpos sequence 0..799,0; vpos goes 0->1 at cycle 800; line_start high at cycles 0 and 800 only.
- REQ-035 SHALL verify: run through line 0 -> hsync low for exactly 96 cycles, hpos 656..751; display_on low from hpos 640 to 799.
- REQ-036 SHALL verify: run a full frame of 420000 cycles -> vsync low only on lines 490-491; frame_start pulses at cycles 0 and 420000; frame_cnt=1 (macro defined) or 0 (macro undefined).
- REQ-037 SHALL verify: hold ena low for 50 cycles at hpos 700 -> all outputs unchanged during the hold; hpos=701 on the first enabled cycle after it.
- REQ-038 SHALL verify: assert rst_n at hpos 700, vpos 491 (both syncs low) -> immediately hpos=0, vpos=0, hsync=1, vsync=1, frame_cnt=0.
- REQ-039 SHALL verify: run 256 frames with the macro defined -> frame_cnt wraps 255->0 on the vpos wrap.
